// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART program loader.
// Optional idle timeout is built when UART_LOADER_TIMEOUT_EN is defined.
package uart_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA_HI,
        DATA_LO,
        CHECK,
        DONE,
        ERROR
    } loader_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    localparam logic [7:0] SYNC_BYTE_DEF  = 8'hA5;
    localparam int         TIMEOUT_CYCLES = 50_000_000;

    function automatic logic is_loading(loader_state_t s);
        return (s == LEN_HI) || (s == LEN_LO) || (s == DATA_HI) ||
               (s == DATA_LO) || (s == CHECK);
    endfunction

endpackage

// File: rtl/uart_program_loader_if.sv
// ROM write-side bus driven by the program loader.
// The loader is the master; the ROM write port is the slave.
interface uart_program_loader_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 12
);
    logic                  rom_we;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_wdata;

    modport master (output rom_we, rom_addr, rom_wdata);
    modport slave  (input  rom_we, rom_addr, rom_wdata);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchroniser, bit timer, shift register.
// Emits a one-cycle byte_valid or frame_err per received byte.
module uart_rx
    import uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       byte_valid,
    output logic       frame_err
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);

    logic          rx_m, rx_s, rx_d;
    rx_state_t     state, state_nx;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic          half_tick, bit_tick;

    assign half_tick = (cnt == CW'(CLKS_PER_BIT / 2 - 1));
    assign bit_tick  = (cnt == CW'(CLKS_PER_BIT - 1));

    // Two-flop synchroniser plus one delay flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    // Receiver state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RX_IDLE;
        else        state <= state_nx;
    end

    // Next state: start edge, mid-start recheck, 8 data bits, stop
    always_comb begin
        state_nx = state;
        unique case (state)
            RX_IDLE:  if (!rx_s && rx_d) state_nx = RX_START;
            RX_START: if (half_tick) state_nx = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (bit_tick && bit_idx == 3'd7) state_nx = RX_STOP;
            RX_STOP:  if (bit_tick) state_nx = RX_IDLE;
            default:  state_nx = RX_IDLE;
        endcase
    end

    // Bit timer, shift register and result pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            bit_idx    <= '0;
            data       <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (state == RX_IDLE || state != state_nx || bit_tick)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            if (state == RX_START)
                bit_idx <= '0;
            if (state == RX_DATA && bit_tick) begin
                data    <= {rx_s, data[7:1]};
                bit_idx <= bit_idx + 1'b1;
            end
            if (state == RX_STOP && bit_tick) begin
                byte_valid <= rx_s;
                frame_err  <= ~rx_s;
            end
        end
    end

endmodule

// File: rtl/uart_program_loader.sv
// Loads a framed program image from UART into the instruction ROM.
// Define UART_LOADER_TIMEOUT_EN to abort frames idle for 1 s.
module uart_program_loader
    import uart_loader_pkg::*;
#(
    parameter int         DATA_WIDTH   = 16,
    parameter int         ADDR_WIDTH   = 12,
    parameter int         CLKS_PER_BIT = 434,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF
) (
    input  logic                   CLK_50,
    input  logic                   resetN,
    input  logic                   rx,
    uart_program_loader_if.master  rom,
    output logic                   load_active,
    output logic                   load_done,
    output logic                   load_error
);
    localparam int MAX_LEN = 2 ** ADDR_WIDTH;

    logic [7:0]        byte_data;
    logic              byte_valid, frame_err;
    loader_state_t     state, state_nx;
    logic [7:0]        len_hi, hi, chk;
    logic [15:0]       len, len_rx;
    logic [ADDR_WIDTH:0] count;
    logic              timeout;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (CLK_50),
        .rst_n      (resetN),
        .rx         (rx),
        .data       (byte_data),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    assign len_rx = {len_hi, byte_data};

`ifdef UART_LOADER_TIMEOUT_EN
    logic [25:0] idle_cnt;

    // Idle watchdog: cleared by each byte, runs only mid-frame
    always_ff @(posedge CLK_50 or negedge resetN) begin
        if (!resetN)                          idle_cnt <= '0;
        else if (!is_loading(state) || byte_valid) idle_cnt <= '0;
        else if (!timeout)                    idle_cnt <= idle_cnt + 1'b1;
    end

    assign timeout = (idle_cnt == 26'(TIMEOUT_CYCLES));
`else
    assign timeout = 1'b0;
`endif

    // Loader state register
    always_ff @(posedge CLK_50 or negedge resetN) begin
        if (!resetN) state <= IDLE;
        else         state <= state_nx;
    end

    // Frame parser next state
    always_comb begin
        state_nx = state;
        if (byte_valid) begin
            unique case (state)
                IDLE, DONE, ERROR:
                    if (byte_data == SYNC_BYTE) state_nx = LEN_HI;
                LEN_HI:  state_nx = LEN_LO;
                LEN_LO:
                    if (len_rx == 16'd0)          state_nx = CHECK;
                    else if (int'(len_rx) > MAX_LEN) state_nx = ERROR;
                    else                          state_nx = DATA_HI;
                DATA_HI: state_nx = DATA_LO;
                DATA_LO:
                    state_nx = (16'(count) + 16'd1 == len) ? CHECK : DATA_HI;
                CHECK:   state_nx = (byte_data == chk) ? DONE : ERROR;
                default: state_nx = IDLE;
            endcase
        end
        if (is_loading(state) && (frame_err || timeout))
            state_nx = ERROR;
    end

    // Datapath: length, checksum, word assembly, ROM strobe, status
    always_ff @(posedge CLK_50 or negedge resetN) begin
        if (!resetN) begin
            len_hi        <= '0;
            len           <= '0;
            hi            <= '0;
            chk           <= '0;
            count         <= '0;
            rom.rom_we    <= 1'b0;
            rom.rom_addr  <= '0;
            rom.rom_wdata <= '0;
            load_active   <= 1'b0;
            load_done     <= 1'b0;
            load_error    <= 1'b0;
        end else begin
            rom.rom_we <= 1'b0;
            if (rom.rom_we)
                count <= count + 1'b1;
            if (byte_valid) begin
                unique case (state)
                    IDLE, DONE, ERROR:
                        if (byte_data == SYNC_BYTE) begin
                            count <= '0;
                            chk   <= '0;
                        end
                    LEN_HI: begin
                        len_hi <= byte_data;
                        chk    <= chk + byte_data;
                    end
                    LEN_LO: begin
                        len <= len_rx;
                        chk <= chk + byte_data;
                    end
                    DATA_HI: begin
                        hi  <= byte_data;
                        chk <= chk + byte_data;
                    end
                    DATA_LO: begin
                        rom.rom_we    <= 1'b1;
                        rom.rom_addr  <= count[ADDR_WIDTH-1:0];
                        rom.rom_wdata <= DATA_WIDTH'({hi, byte_data});
                        chk           <= chk + byte_data;
                    end
                    default: ;
                endcase
            end
            load_active <= is_loading(state_nx);
            load_done   <= (state_nx == DONE);
            load_error  <= (state_nx == ERROR);
        end
    end

endmodule

// File: tb/tb_uart_program_loader.sv
// Scoreboard bench for uart_program_loader at CLKS_PER_BIT=8.
// Expected ROM writes are queued as words are sent, popped on rom_we.
module tb_uart_program_loader;

    localparam int CPB = 8;

    typedef logic [7:0] bytes_t[$];

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rx    = 1'b1;
    logic load_active, load_done, load_error;

    int errors = 0;
    int checks = 0;

    logic [27:0] exp_q[$];

    uart_program_loader_if #(.DATA_WIDTH(16), .ADDR_WIDTH(12)) rom_bus ();

    uart_program_loader #(
        .DATA_WIDTH   (16),
        .ADDR_WIDTH   (12),
        .CLKS_PER_BIT (CPB),
        .SYNC_BYTE    (8'hA5)
    ) dut (
        .CLK_50      (clk),
        .resetN      (rst_n),
        .rx          (rx),
        .rom         (rom_bus),
        .load_active (load_active),
        .load_done   (load_done),
        .load_error  (load_error)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every strobe must match the oldest queued write
    always @(negedge clk) begin
        if (rst_n && rom_bus.rom_we === 1'b1) begin
            check("we_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0)
                check("rom_write", {4'h0, rom_bus.rom_addr, rom_bus.rom_wdata},
                      {4'h0, exp_q.pop_front()});
        end
    end

    function automatic logic [7:0] csum(input bytes_t b);
        logic [7:0] s = 8'h00;
        foreach (b[i]) s = s + b[i];
        return s;
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        @(negedge clk) rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_bytes(input bytes_t b);
        foreach (b[i]) send_byte(b[i]);
    endtask

    task automatic check_status(input string tag, input logic act,
                                input logic done, input logic err);
        check({tag, "_active"}, 32'(load_active), 32'(act));
        check({tag, "_done"},   32'(load_done),   32'(done));
        check({tag, "_error"},  32'(load_error),  32'(err));
        check({tag, "_pending"}, exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        bytes_t body;

        repeat (5) @(negedge clk);
        check("rst_we",   32'(rom_bus.rom_we),    0);
        check("rst_addr", 32'(rom_bus.rom_addr),  0);
        check("rst_data", 32'(rom_bus.rom_wdata), 0);
        check_status("rst", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Two-word frame with good checksum
        body = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        send_byte(8'hA5);
        check("f1_active_after_sync", 32'(load_active), 1);
        exp_q.push_back({12'd0, 16'h1234});
        exp_q.push_back({12'd1, 16'hABCD});
        send_bytes(body);
        check("f1_active_before_chk", 32'(load_active), 1);
        send_byte(csum(body));
        check_status("f1", 1'b0, 1'b1, 1'b0);

        // Junk bytes ignored, then an empty frame
        body = '{8'h00, 8'h00};
        send_bytes('{8'h00, 8'hFF});
        check("junk_active", 32'(load_active), 0);
        send_byte(8'hA5);
        send_bytes(body);
        send_byte(csum(body));
        check_status("empty", 1'b0, 1'b1, 1'b0);

        // One word, wrong checksum (correct would be 8C)
        exp_q.push_back({12'd0, 16'hDEAD});
        send_bytes('{8'hA5, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'h00});
        check_status("badchk", 1'b0, 1'b0, 1'b1);

        // Length just above the ROM size
        send_bytes('{8'hA5, 8'h10, 8'h01});
        check_status("badlen", 1'b0, 1'b0, 1'b1);

        // Framing error while the low data byte arrives
        send_bytes('{8'hA5, 8'h00, 8'h01, 8'hDE});
        check("ferr_pre_active", 32'(load_active), 1);
        send_byte(8'hAD, 1'b0);
        check_status("ferr", 1'b0, 1'b0, 1'b1);

        // Recovery frame clears the error
        body = '{8'h00, 8'h01, 8'hBE, 8'hEF};
        exp_q.push_back({12'd0, 16'hBEEF});
        send_byte(8'hA5);
        check("recov_error_cleared", 32'(load_error), 0);
        send_bytes(body);
        send_byte(csum(body));
        check_status("recov", 1'b0, 1'b1, 1'b0);

        // Reset in the middle of a word
        send_bytes('{8'hA5, 8'h00, 8'h01, 8'h12});
        @(negedge clk) rx = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        check("midrst_pre_active", 32'(load_active), 1);
        #3 rst_n = 1'b0;
        #1;
        check_status("midrst", 1'b0, 1'b0, 1'b0);
        check("midrst_we", 32'(rom_bus.rom_we), 0);
        rx = 1'b1;
        repeat (20 * CPB) @(negedge clk);
        rst_n = 1'b1;
        repeat (20 * CPB) @(negedge clk);
        check_status("postrst", 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
